// File: rtl/split_initiator_if.sv
// Bundle of command/response and bus-side signals for split_initiator.
// master = initiator view; slave = requester/arbiter/target view.
interface split_initiator_if;
    logic        cmd_valid;
    logic        cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        bus_req;
    logic        bus_grant;
    logic [15:0] m_address_out;
    logic        m_address_out_valid;
    logic [7:0]  m_data_out;
    logic        m_data_out_valid;
    logic        m_rw;
    logic        m_ready;
    logic [7:0]  m_data_in;
    logic        m_data_in_valid;
    logic        m_ack;
    logic        m_split_ack;
    logic        split_pending;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output bus_req,
        input  bus_grant,
        output m_address_out, m_address_out_valid,
        output m_data_out, m_data_out_valid, m_rw,
        input  m_ready, m_data_in, m_data_in_valid,
        input  m_ack, m_split_ack,
        output split_pending
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  bus_req,
        output bus_grant,
        input  m_address_out, m_address_out_valid,
        input  m_data_out, m_data_out_valid, m_rw,
        output m_ready, m_data_in, m_data_in_valid,
        output m_ack, m_split_ack,
        input  split_pending
    );
endinterface

// File: rtl/split_initiator.sv
// Split-capable bus initiator: one command at a time, arbitration, addr phase.
// Optional watchdog on response waits: define SPLIT_INIT_TIMEOUT_EN.
module split_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst_n,
    split_initiator_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WAIT_RESP,
        S_SPLIT_WAIT
    } state_t;

    state_t      state, state_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic [7:0]  rdata_q, rdata_n;
    logic        rw_q, rw_n;
    logic        req_q, req_n;
    logic        av_q, av_n;
    logic        dv_q, dv_n;
    logic        rv_q, rv_n;
    logic        sp_q, sp_n;
    logic        ack_done;
    logic        ret_done;

    // A zero limit would make the watchdog fire immediately.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_limit
    end

    assign ack_done = bus.m_ack && (rw_q || bus.m_data_in_valid);
    assign ret_done = bus.m_ack && bus.m_data_in_valid;

`ifdef SPLIT_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          tmo;
    logic          err_q, err_n;

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (state_n != state)
            cnt_q <= '0;
        else if (state == S_WAIT_RESP || state == S_SPLIT_WAIT)
            cnt_q <= cnt_q + 1'b1;
    end
`endif

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        rw_n    = rw_q;
        req_n   = req_q;
        av_n    = av_q;
        dv_n    = dv_q;
        sp_n    = sp_q;
        rv_n    = 1'b0;
`ifdef SPLIT_INIT_TIMEOUT_EN
        err_n   = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_n  = bus.cmd_addr;
                    wdata_n = bus.cmd_wdata;
                    rw_n    = bus.cmd_rw;
                    req_n   = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bus_grant) begin
                    av_n    = 1'b1;
                    dv_n    = rw_q;
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.m_ready) begin
                    av_n    = 1'b0;
                    dv_n    = 1'b0;
                    state_n = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A full ack beats a simultaneous split ack.
                if (ack_done) begin
                    if (!rw_q)
                        rdata_n = bus.m_data_in;
                    rv_n    = 1'b1;
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end else if (bus.m_split_ack) begin
                    req_n   = 1'b0;
                    sp_n    = 1'b1;
                    state_n = S_SPLIT_WAIT;
                end
`ifdef SPLIT_INIT_TIMEOUT_EN
                else if (tmo) begin
                    rdata_n = 8'h00;
                    err_n   = 1'b1;
                    rv_n    = 1'b1;
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end
`endif
            end
            S_SPLIT_WAIT: begin
                if (ret_done) begin
                    rdata_n = bus.m_data_in;
                    rv_n    = 1'b1;
                    sp_n    = 1'b0;
                    state_n = S_IDLE;
                end
`ifdef SPLIT_INIT_TIMEOUT_EN
                else if (tmo) begin
                    rdata_n = 8'h00;
                    err_n   = 1'b1;
                    rv_n    = 1'b1;
                    sp_n    = 1'b0;
                    state_n = S_IDLE;
                end
`endif
            end
            default: begin
                req_n   = 1'b0;
                av_n    = 1'b0;
                dv_n    = 1'b0;
                sp_n    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            req_q   <= 1'b0;
            av_q    <= 1'b0;
            dv_q    <= 1'b0;
            rv_q    <= 1'b0;
            sp_q    <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            rw_q    <= rw_n;
            req_q   <= req_n;
            av_q    <= av_n;
            dv_q    <= dv_n;
            rv_q    <= rv_n;
            sp_q    <= sp_n;
        end
    end

`ifdef SPLIT_INIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_n;
    end

    assign bus.rsp_error = err_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

    // Gated so every output reads 0 while reset is held.
    assign bus.cmd_ready           = rst_n && (state == S_IDLE);
    assign bus.rsp_valid           = rv_q;
    assign bus.rsp_rdata           = rdata_q;
    assign bus.bus_req             = req_q;
    assign bus.m_address_out       = addr_q;
    assign bus.m_address_out_valid = av_q;
    assign bus.m_data_out          = wdata_q;
    assign bus.m_data_out_valid    = dv_q;
    assign bus.m_rw                = rw_q;
    assign bus.split_pending       = sp_q;

endmodule

// File: tb/tb_split_initiator.sv
// Bench for split_initiator: directed plus random transfers against a
// cycle-timeline reference model built from the edge-level timing rules.
module tb_split_initiator;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    split_initiator_if bus ();

    split_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] exp_rdata = 8'h00;

    // Current transfer plan, in edges counted from command acceptance (edge 0)
    bit          p_rw, p_split, p_noret, p_both;
    logic [15:0] p_addr;
    logic [7:0]  p_wd, p_rd;
    int          tg, ta, tk, tend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.bus_grant       = 1'b0;
        bus.m_ready         = 1'b0;
        bus.m_ack           = 1'b0;
        bus.m_split_ack     = 1'b0;
        bus.m_data_in_valid = 1'b0;
        bus.m_data_in       = 8'h00;
    endtask

    task automatic plan(input bit rw, input logic [15:0] a,
                        input logic [7:0] wd, input int g, input int r,
                        input int d, input bit sp, input int lat,
                        input logic [7:0] rd, input bit both,
                        input bit noret);
        p_rw    = rw;
        p_addr  = a;
        p_wd    = wd;
        p_split = sp;
        p_rd    = rd;
        p_both  = both;
        p_noret = noret;
        tg      = 1 + g;
        ta      = tg + 1 + r;
        tk      = ta + 1 + d;
        if (!sp)
            tend = tk;
        else if (noret)
            tend = tk + TMO;
        else
            tend = tk + lat;
    endtask

    // Inputs the target/arbiter present for sampling at edge e
    task automatic drive(input int e);
        bus.m_data_in = 8'($urandom);
        if (e < tg)
            bus.bus_grant = 1'b0;
        else if (e == tg)
            bus.bus_grant = 1'b1;
        else
            bus.bus_grant = 1'($urandom);
        if (e > tg && e < ta)
            bus.m_ready = 1'b0;
        else if (e == ta)
            bus.m_ready = 1'b1;
        else
            bus.m_ready = 1'($urandom);
        if (e <= ta) begin
            bus.m_ack           = 1'($urandom);
            bus.m_split_ack     = 1'($urandom);
            bus.m_data_in_valid = 1'($urandom);
        end else if (e < tk) begin
            bus.m_ack           = 1'b0;
            bus.m_split_ack     = 1'b0;
            bus.m_data_in_valid = 1'($urandom);
        end else if (e == tk) begin
            if (p_split) begin
                bus.m_ack           = 1'b0;
                bus.m_split_ack     = 1'b1;
                bus.m_data_in_valid = 1'($urandom);
            end else begin
                bus.m_ack       = 1'b1;
                bus.m_split_ack = p_both;
                if (p_rw)
                    bus.m_data_in_valid = 1'($urandom);
                else begin
                    bus.m_data_in_valid = 1'b1;
                    bus.m_data_in       = p_rd;
                end
            end
        end else if (e == tend && !p_noret) begin
            bus.m_ack           = 1'b1;
            bus.m_split_ack     = 1'($urandom);
            bus.m_data_in_valid = 1'b1;
            bus.m_data_in       = p_rd;
        end else if (e <= tend) begin
            bus.m_ack           = 1'($urandom);
            bus.m_split_ack     = 1'($urandom);
            bus.m_data_in_valid = bus.m_ack ? 1'b0 : 1'($urandom);
        end else begin
            bus.m_ack           = 1'b0;
            bus.m_split_ack     = 1'b0;
            bus.m_data_in_valid = 1'b0;
        end
    endtask

    task automatic check_cycle(input int k);
        bit av;
        av = (k >= tg) && (k < ta);
        chk("bus_req", 32'(bus.bus_req), 32'(k < tk));
        chk("addr_valid", 32'(bus.m_address_out_valid), 32'(av));
        chk("data_valid", 32'(bus.m_data_out_valid), 32'(av && p_rw));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(k == tend));
        chk("split_pending", 32'(bus.split_pending),
            32'(p_split && k >= tk && k < tend));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(k >= tend));
        if (av) begin
            chk("m_address_out", 32'(bus.m_address_out), 32'(p_addr));
            chk("m_rw", 32'(bus.m_rw), 32'(p_rw));
            if (p_rw)
                chk("m_data_out", 32'(bus.m_data_out), 32'(p_wd));
        end
        if (k == tend) begin
            if (p_noret)
                exp_rdata = 8'h00;
            else if (!p_rw)
                exp_rdata = p_rd;
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
            chk("rsp_error", 32'(bus.rsp_error), 32'(p_noret));
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_bus_req"}, 32'(bus.bus_req), 0);
        chk({tag, "_addr_valid"}, 32'(bus.m_address_out_valid), 0);
        chk({tag, "_data_valid"}, 32'(bus.m_data_out_valid), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 0);
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
        chk({tag, "_split_pending"}, 32'(bus.split_pending), 0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        chk({tag, "_m_address_out"}, 32'(bus.m_address_out), 0);
        chk({tag, "_m_data_out"}, 32'(bus.m_data_out), 0);
        chk({tag, "_m_rw"}, 32'(bus.m_rw), 0);
    endtask

    // Runs the planned transfer; abort pulses reset one cycle into split wait
    task automatic txn(input bit abort);
        chk("cmd_ready_start", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = p_rw;
        bus.cmd_addr  = p_addr;
        bus.cmd_wdata = p_wd;
        drive(0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'($urandom);
        bus.cmd_addr  = 16'($urandom);
        bus.cmd_wdata = 8'($urandom);
        for (int k = 0; k <= tend; k++) begin
            check_cycle(k);
            if (abort && k == tk + 1) begin
                #2;
                rst_n = 1'b0;
                quiet();
                #1;
                reset_checks("rst_mid");
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                exp_rdata = 8'h00;
                chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
                chk("rst_bus_req", 32'(bus.bus_req), 0);
                chk("rst_split_pending", 32'(bus.split_pending), 0);
                bus.m_ack           = 1'b1;
                bus.m_data_in_valid = 1'b1;
                bus.m_data_in       = p_rd;
                @(posedge clk);
                #1;
                chk("late_ack_rsp_valid", 32'(bus.rsp_valid), 0);
                chk("late_ack_rdata", 32'(bus.rsp_rdata), 0);
                chk("late_ack_cmd_ready", 32'(bus.cmd_ready), 1);
                quiet();
                return;
            end
            drive(k + 1);
            @(posedge clk);
            #1;
        end
        chk("rsp_pulse_end", 32'(bus.rsp_valid), 0);
        chk("cmd_ready_end", 32'(bus.cmd_ready), 1);
        chk("bus_req_end", 32'(bus.bus_req), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = 16'h0000;
        bus.cmd_wdata = 8'h00;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Minimum write, ack one cycle after the address
        plan(1'b1, 16'h0005, 8'hA5, 0, 0, 0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        txn(1'b0);
        // Split read, latency 4
        plan(1'b0, 16'h0003, 8'h00, 0, 0, 0, 1'b1, 4, 8'h3C, 1'b0, 1'b0);
        txn(1'b0);
        // Late grant and a stalled address phase
        plan(1'b1, 16'h1234, 8'h5A, 3, 2, 1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        txn(1'b0);
        // Ack and split ack together on a read
        plan(1'b0, 16'h0042, 8'h00, 0, 0, 0, 1'b0, 0, 8'h77, 1'b1, 1'b0);
        txn(1'b0);
        // Reset while waiting for split data
        plan(1'b0, 16'h0099, 8'h00, 1, 0, 0, 1'b1, 4, 8'hE1, 1'b0, 1'b0);
        txn(1'b1);
        // Write after a read keeps the read data
        plan(1'b0, 16'h0010, 8'h00, 0, 1, 2, 1'b0, 0, 8'hC3, 1'b0, 1'b0);
        txn(1'b0);
        plan(1'b1, 16'hFFFF, 8'hFF, 2, 0, 0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        txn(1'b0);

        for (int i = 0; i < 40; i++) begin
            bit rw;
            bit sp;
            rw = 1'($urandom);
            sp = !rw && 1'($urandom);
            plan(rw, 16'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), sp,
                 int'($urandom_range(1, 6)), 8'($urandom),
                 1'($urandom), 1'b0);
            txn(1'b0);
        end

`ifdef SPLIT_INIT_TIMEOUT_EN
        // Split read whose data never comes back
        plan(1'b0, 16'h0777, 8'h00, 0, 0, 1, 1'b1, 0, 8'h5D, 1'b0, 1'b1);
        txn(1'b0);
        plan(1'b0, 16'h0778, 8'h00, 1, 1, 0, 1'b1, 3, 8'h81, 1'b0, 1'b0);
        txn(1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/split_initiator.md
# split_initiator

Master-side bus port for the dual-bus system: accepts one read or write command at a time from a local requester, wins the bus through the arbiter, and drives the address/data/rw phase toward a target. It completes immediate (acked) transfers directly. For split reads it releases the bus on `m_split_ack` and waits for the target's deferred data return. It is the initiator counterpart of the split-capable target and works unchanged against non-split targets.

## Interface
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles for `S_WAIT_RESP`/`S_SPLIT_WAIT`; only used when `SPLIT_INIT_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  local command present.
- `cmd_rw`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  16  target address.
- `cmd_wdata`  in  8  write data.
- `cmd_ready`  out  1  high only in `S_IDLE`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; held until the next completion.
- `rsp_error`  out  1  timeout completion, valid with `rsp_valid`.
- `bus_req`  out  1  request to arbiter.
- `bus_grant`  in  1  arbiter grant.
- `m_address_out`  out  16  address to target.
- `m_address_out_valid`  out  1  address phase.
- `m_data_out`  out  8  write data to target.
- `m_data_out_valid`  out  1  write data phase.
- `m_rw`  out  1  copy of latched `cmd_rw`.
- `m_ready`  in  1  target ready.
- `m_data_in`  in  8  read data from target.
- `m_data_in_valid`  in  1  read data valid.
- `m_ack`  in  1  target completion.
- `m_split_ack`  in  1  target deferred the read.
- `split_pending`  out  1  high in `S_SPLIT_WAIT`.

## Operation
- Reset: all outputs 0, state `S_IDLE`; internal registers cleared. Reset in any state abandons the transfer with no `rsp_valid`.
- `S_IDLE`: `cmd_ready`=1. On `cmd_valid`, latch addr, wdata and rw, then go to `S_REQ`.
- `S_REQ`: `bus_req`=1. When `bus_grant` is sampled high, go to `S_ADDR`.
- `S_ADDR`: `bus_req`=1 and `m_address_out_valid`=1; `m_data_out_valid`=`m_rw`. The phase completes on a cycle where `m_ready`=1; valids are then cleared and the block enters `S_WAIT_RESP`. With `m_ready` low, the valids are held.
- `S_WAIT_RESP`: `bus_req`=1.
  - `m_ack` (write) completes the transfer.
  - `m_ack` with `m_data_in_valid` (read) captures `m_data_in` and completes.
  - `m_split_ack` moves to `S_SPLIT_WAIT` and drops `bus_req` the next cycle.
  - If `m_ack` and `m_split_ack` arrive together, `m_ack` wins.
- `S_SPLIT_WAIT`: `bus_req`=0, `split_pending`=1. `m_ack` with `m_data_in_valid` captures data and completes. `m_split_ack` is ignored.
- Completion: `rsp_valid`=1 for one cycle, `rsp_error`=0, return to `S_IDLE`. `bus_req` deasserts on the same edge.
- `m_ack`, `m_split_ack` and `m_data_in_valid` are ignored in `S_IDLE`, `S_REQ` and `S_ADDR`. Loss of `bus_grant` after `S_REQ` is ignored.

## Timing
- Command accepted at edge N → `bus_req`=1 from N+1.
- `bus_grant` sampled at edge G → address valid from G+1.
- With `m_ready`=1, address/data are valid for exactly one cycle.
- `m_ack` sampled at edge A → `rsp_valid` and `rsp_rdata` update at A+1; `cmd_ready`=1 from A+1.
- Minimum write: command to `rsp_valid` is 4 cycles when the grant and ack are immediate.
- All outputs are registered; no combinational input→output paths except `cmd_ready`, which is decoded from state.

## Configuration
- `SPLIT_INIT_TIMEOUT_EN` defined:
  - A counter is cleared on entry to `S_WAIT_RESP` or `S_SPLIT_WAIT` and increments each cycle there.
  - When it reaches `TIMEOUT_CYCLES`, the block issues `rsp_valid`=1 with `rsp_error`=1 and `rsp_rdata`=0x00, drops `bus_req`, and returns to `S_IDLE`.
  - A target ack on the same cycle as the timeout wins.
- Not defined: no counter; waits are unbounded; `rsp_error` is tied 0.

## Test plan
- Write addr 0x0005 data 0xA5, grant immediate, target acks 1 cycle after the address → `m_data_out`=0xA5 with the address; `rsp_valid` 4 cycles after the command; `rsp_error`=0.
- Read addr 0x0003 from a split target with read latency 4 and memory 0x3C → `m_split_ack`; `bus_req` drops; `split_pending`=1; the data return yields `rsp_rdata`=0x3C and `split_pending`=0.
- Grant delayed 3 cycles, then `m_ready` low 2 cycles in `S_ADDR` → `bus_req` held throughout; address valid for exactly 3 cycles; a single transfer.
- Simultaneous `m_ack`+`m_split_ack`+`m_data_in_valid`=0x77 on a read → immediate completion with `rsp_rdata`=0x77; no split wait.
- `rst_n` pulsed low during `S_SPLIT_WAIT` → all outputs 0; no `rsp_valid`; `cmd_ready`=1 after release; a later late `m_ack` is ignored.
- With `SPLIT_INIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, a split read that never returns → `rsp_valid` with `rsp_error`=1 and `rsp_rdata`=0x00, 8 cycles after entering `S_SPLIT_WAIT`.
